// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit for the nrisc 8-bit processor.
// It sequences fetch, decode, execute, memory and write-back over a shared
// instruction/data memory with a ready handshake, and owns the Halt state.
//
// Handshake: a memory access is requested by holding MemLe or MemEsc high
// together with SelEndereco. The access completes in the cycle where
// MemPronto=1; until then every strobe and the address select stay
// constant. MemPronto is ignored in every other state.
module unidade_controle (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Instr,
    input  logic       Zero,
    input  logic       MemPronto,
    input  logic       Continuar,
    output logic       PcEsc,
    output logic       PcSelSalto,
    output logic       IrEsc,
    output logic       RegEsc,
    output logic       SelDadoEscrito,
    output logic [1:0] UlaOp,
    output logic       MemLe,
    output logic       MemEsc,
    output logic       SelEndereco,
    output logic       Halt,
    output logic [2:0] Estado
);

    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        DECOD   = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        ESCRITA = 3'd4,
        PARADO  = 3'd5
    } estado_t;

    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_BEQZ = 3'b110;
    localparam logic [2:0] OP_ESP  = 3'b111;

    estado_t estado_atual;
    estado_t proximo;

    // Instruction field decode. Instr is held stable by the datapath from
    // DECOD until the instruction completes, so it is decoded directly.
    logic [2:0] opcode;
    logic       eh_alu;
    logic       eh_ld;
    logic       eh_st;
    logic       eh_beqz;
    logic       eh_hlt;
    logic       eh_nop;

    assign opcode  = Instr[7:5];
    assign eh_alu  = (opcode[2] == 1'b0);
    assign eh_ld   = (opcode == OP_LD);
    assign eh_st   = (opcode == OP_ST);
    assign eh_beqz = (opcode == OP_BEQZ);
    assign eh_hlt  = (opcode == OP_ESP) && (Instr[4:0] == 5'd0);
    assign eh_nop  = (opcode == OP_ESP) && (Instr[4:0] != 5'd0);

    // Ungated decodes; the reset gate below forces them to zero.
    logic       pc_esc_c;
    logic       pc_sel_salto_c;
    logic       ir_esc_c;
    logic       reg_esc_c;
    logic       sel_dado_c;
    logic [1:0] ula_op_c;
    logic       mem_le_c;
    logic       mem_esc_c;
    logic       sel_end_c;
    logic       halt_c;

    // State register: asynchronous abort back to BUSCA.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_atual <= BUSCA;
        end else begin
            estado_atual <= proximo;
        end
    end

    // Next-state and output decode of state, Instr, MemPronto and Zero.
    always_comb begin
        proximo        = estado_atual;
        pc_esc_c       = 1'b0;
        pc_sel_salto_c = 1'b0;
        ir_esc_c       = 1'b0;
        reg_esc_c      = 1'b0;
        sel_dado_c     = 1'b0;
        ula_op_c       = 2'b00;
        mem_le_c       = 1'b0;
        mem_esc_c      = 1'b0;
        sel_end_c      = 1'b0;
        halt_c         = 1'b0;

        case (estado_atual)
            BUSCA: begin
                // Instruction fetch from PC; IR and PC update only on the
                // completing cycle so a stall leaves both untouched.
                mem_le_c  = 1'b1;
                sel_end_c = 1'b0;
                if (MemPronto) begin
                    ir_esc_c = 1'b1;
                    pc_esc_c = 1'b1;
                    proximo  = DECOD;
                end
            end

            DECOD: begin
                // Register read cycle: no strobes, only dispatch.
                if (eh_alu || eh_beqz) begin
                    proximo = EXEC;
                end else if (eh_ld || eh_st) begin
                    proximo = MEM;
                end else if (eh_hlt) begin
                    proximo = PARADO;
                end else if (eh_nop) begin
                    proximo = BUSCA;
                end else begin
                    proximo = BUSCA;
                end
            end

            EXEC: begin
                if (eh_alu) begin
                    ula_op_c = opcode[1:0];
                    proximo  = ESCRITA;
                end else if (eh_beqz) begin
                    // Branch taken: PC loads register rs.
                    if (Zero) begin
                        pc_esc_c       = 1'b1;
                        pc_sel_salto_c = 1'b1;
                    end
                    proximo = BUSCA;
                end else begin
                    proximo = BUSCA;
                end
            end

            MEM: begin
                // Data access at address rs; strobes held across stalls.
                sel_end_c = 1'b1;
                mem_le_c  = eh_ld;
                mem_esc_c = eh_st;
                if (MemPronto) begin
                    proximo = eh_ld ? ESCRITA : BUSCA;
                end
            end

            ESCRITA: begin
                // Write-back to rd; ALU result keeps its operation selected.
                reg_esc_c  = 1'b1;
                sel_dado_c = eh_ld;
                if (eh_alu) begin
                    ula_op_c = opcode[1:0];
                end
                proximo = BUSCA;
            end

            PARADO: begin
                halt_c = 1'b1;
                if (Continuar) begin
                    proximo = BUSCA;
                end
            end

            default: begin
                // Unused codes recover to fetch with every output low.
                proximo = BUSCA;
            end
        endcase
    end

    // Output gate: everything reads zero while Reset is asserted.
    always_comb begin
        PcEsc          = 1'b0;
        PcSelSalto     = 1'b0;
        IrEsc          = 1'b0;
        RegEsc         = 1'b0;
        SelDadoEscrito = 1'b0;
        UlaOp          = 2'b00;
        MemLe          = 1'b0;
        MemEsc         = 1'b0;
        SelEndereco    = 1'b0;
        Halt           = 1'b0;
        Estado         = 3'd0;
        if (Reset) begin
            PcEsc          = pc_esc_c;
            PcSelSalto     = pc_sel_salto_c;
            IrEsc          = ir_esc_c;
            RegEsc         = reg_esc_c;
            SelDadoEscrito = sel_dado_c;
            UlaOp          = ula_op_c;
            MemLe          = mem_le_c;
            MemEsc         = mem_esc_c;
            SelEndereco    = sel_end_c;
            Halt           = halt_c;
            Estado         = estado_atual;
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed instruction table, hand-written reset
// sequences and randomized instruction streams against a cycle-plan model.
module tb_unidade_controle;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Instr;
    logic       Zero;
    logic       MemPronto;
    logic       Continuar;
    logic       PcEsc;
    logic       PcSelSalto;
    logic       IrEsc;
    logic       RegEsc;
    logic       SelDadoEscrito;
    logic [1:0] UlaOp;
    logic       MemLe;
    logic       MemEsc;
    logic       SelEndereco;
    logic       Halt;
    logic [2:0] Estado;

    localparam int W = 14;

    unidade_controle dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Instr          (Instr),
        .Zero           (Zero),
        .MemPronto      (MemPronto),
        .Continuar      (Continuar),
        .PcEsc          (PcEsc),
        .PcSelSalto     (PcSelSalto),
        .IrEsc          (IrEsc),
        .RegEsc         (RegEsc),
        .SelDadoEscrito (SelDadoEscrito),
        .UlaOp          (UlaOp),
        .MemLe          (MemLe),
        .MemEsc         (MemEsc),
        .SelEndereco    (SelEndereco),
        .Halt           (Halt),
        .Estado         (Estado)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    logic [W-1:0] act;
    assign act = {PcEsc, PcSelSalto, IrEsc, RegEsc, SelDadoEscrito, UlaOp,
                  MemLe, MemEsc, SelEndereco, Halt, Estado};

    int compared   = 0;
    int mismatched = 0;

    // One planned cycle: inputs to drive and the outputs required.
    typedef struct {
        logic [7:0] instr;
        logic       mp;
        logic       zero;
        logic       cont;
    } cyc_t;

    cyc_t         plan_q[$];
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [7:0] instr;
        int         sf;
        int         sm;
        logic       zero;
        int         park;
        int         exp_lat;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [W-1:0] pk(input logic pce, input logic pcs,
                                        input logic ire, input logic rege,
                                        input logic sel, input logic [1:0] ula,
                                        input logic mle, input logic mes,
                                        input logic sen, input logic hlt,
                                        input logic [2:0] est);
        return {pce, pcs, ire, rege, sel, ula, mle, mes, sen, hlt, est};
    endfunction

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        compared++;
        if (a != e) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // ---------------- model: instruction -> cycle plan ----------------
    task automatic push(input logic [7:0] ins, input logic mp, input logic z,
                        input logic ct, input logic [W-1:0] e);
        cyc_t c;
        c.instr = ins;
        c.mp    = mp;
        c.zero  = z;
        c.cont  = ct;
        plan_q.push_back(c);
        exp_q.push_back(e);
    endtask

    task automatic build(input logic [7:0] ins, input int sf, input int sm,
                         input logic zero, input int park);
        logic [2:0] op;
        logic       hlt;
        op  = ins[7:5];
        hlt = (op == 3'b111) && (ins[4:0] == 5'd0);
        // fetch: stalls then the completing cycle (Instr is a don't-care)
        for (int k = 0; k < sf; k++)
            push(8'($urandom), 1'b0, rb(), rb(), pk(0,0,0,0,0,2'b00,1,0,0,0,3'd0));
        push(8'($urandom), 1'b1, rb(), rb(), pk(1,0,1,0,0,2'b00,1,0,0,0,3'd0));
        // decode; Continuar here must be ignored even for HLT
        push(ins, rb(), rb(), hlt ? 1'b1 : rb(), pk(0,0,0,0,0,2'b00,0,0,0,0,3'd1));
        if (op[2] == 1'b0) begin
            push(ins, rb(), rb(), rb(), pk(0,0,0,0,0,op[1:0],0,0,0,0,3'd2));
            push(ins, rb(), rb(), rb(), pk(0,0,0,1,0,op[1:0],0,0,0,0,3'd4));
        end else if (op == 3'b110) begin
            push(ins, rb(), zero, rb(), pk(zero,zero,0,0,0,2'b00,0,0,0,0,3'd2));
        end else if (op == 3'b100 || op == 3'b101) begin
            for (int k = 0; k < sm; k++)
                push(ins, 1'b0, rb(), rb(), pk(0,0,0,0,0,2'b00,op==3'b100,op==3'b101,1,0,3'd3));
            push(ins, 1'b1, rb(), rb(), pk(0,0,0,0,0,2'b00,op==3'b100,op==3'b101,1,0,3'd3));
            if (op == 3'b100)
                push(ins, rb(), rb(), rb(), pk(0,0,0,1,1,2'b00,0,0,0,0,3'd4));
        end else if (hlt) begin
            for (int k = 0; k < park - 1; k++)
                push(ins, rb(), rb(), 1'b0, pk(0,0,0,0,0,2'b00,0,0,0,1,3'd5));
            push(ins, rb(), rb(), 1'b1, pk(0,0,0,0,0,2'b00,0,0,0,1,3'd5));
        end
    endtask

    // ---------------- driver ----------------
    // Entry/exit point: 1 time unit after a rising edge.
    // lat = cycles until the DUT itself reports BUSCA again (-1 if never).
    task automatic run_plan(input string tag, input int limit, output int lat);
        int   n;
        logic left;
        n    = (limit < plan_q.size()) ? limit : plan_q.size();
        left = 1'b0;
        lat  = -1;
        for (int i = 0; i < n; i++) begin
            Instr     = plan_q[i].instr;
            MemPronto = plan_q[i].mp;
            Zero      = plan_q[i].zero;
            Continuar = plan_q[i].cont;
            #2;
            if (Estado != 3'd0) left = 1'b1;
            else if (left && lat < 0) lat = i;
            chk($sformatf("%s[%0d]", tag, i), act, exp_q[i]);
            @(posedge Clock);
            #1;
        end
        if (lat < 0 && left && Estado == 3'd0) lat = n;
        plan_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         lat;
        logic [7:0] ins;

        tbl[0] = '{8'b000_011_01, 0, 0, 1'b0, 1, 4};   // ADD
        tbl[1] = '{8'b001_111_00, 2, 0, 1'b0, 1, 6};   // SUB, fetch stall 2
        tbl[2] = '{8'b100_010_11, 0, 3, 1'b0, 1, 7};   // LD, mem stall 3
        tbl[3] = '{8'b110_000_10, 0, 0, 1'b1, 1, 3};   // BEQZ taken
        tbl[4] = '{8'b110_000_10, 0, 0, 1'b0, 1, 3};   // BEQZ not taken
        tbl[5] = '{8'hE0,         0, 0, 1'b0, 10, 12}; // HLT, parked 10
        tbl[6] = '{8'hE5,         0, 0, 1'b0, 1, 2};   // NOP
        tbl[7] = '{8'b101_001_10, 0, 0, 1'b0, 1, 3};   // ST
        tbl[8] = '{8'b011_001_10, 1, 0, 1'b0, 1, 5};   // OR, fetch stall 1
        tbl[9] = '{8'b010_110_01, 0, 2, 1'b0, 1, 4};   // AND, sm irrelevant

        // ---------------- reset ----------------
        Reset = 1'b0; Instr = 8'h00; Zero = 1'b0; MemPronto = 1'b0; Continuar = 1'b0;
        #3;
        chk("reset_outputs_t0", act, '0);
        repeat (2) @(posedge Clock);
        #1;
        MemPronto = 1'b1; Continuar = 1'b1; Zero = 1'b1; Instr = 8'hE0;
        #1;
        chk("reset_outputs_held", act, '0);
        MemPronto = 1'b0; Continuar = 1'b0; Zero = 1'b0;
        Reset = 1'b1;
        #1;
        chk("reset_release_fetch", act, pk(0,0,0,0,0,2'b00,1,0,0,0,3'd0));
        @(posedge Clock);
        #1;

        // ---------------- directed table ----------------
        for (int t = 0; t < 10; t++) begin
            build(tbl[t].instr, tbl[t].sf, tbl[t].sm, tbl[t].zero, tbl[t].park);
            run_plan($sformatf("vec%0d", t), 1000, lat);
            chk_int($sformatf("vec%0d_latency", t), lat, tbl[t].exp_lat);
        end

        // ---------------- reset during a LD stall in MEM ----------------
        build(8'b100_010_11, 0, 8, 1'b0, 1);
        run_plan("ld_stall", 4, lat);   // fetch, decode, 2 stalled MEM cycles
        Instr = 8'b100_010_11; MemPronto = 1'b0;
        #1;
        chk("ld_stall_mem", act, pk(0,0,0,0,0,2'b00,1,0,1,0,3'd3));
        #1;
        Reset = 1'b0;
        #1;
        chk("ld_stall_reset_async", act, '0);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clock);
            #1;
            MemPronto = rb();
            #1;
            chk($sformatf("ld_stall_reset_hold%0d", k), act, '0);
        end
        MemPronto = 1'b0;
        Reset = 1'b1;
        #1;
        chk("ld_stall_release", act, pk(0,0,0,0,0,2'b00,1,0,0,0,3'd0));
        @(posedge Clock);
        #1;

        // ---------------- reset while parked ----------------
        build(8'hE0, 0, 0, 1'b0, 6);
        run_plan("hlt_park", 4, lat);   // fetch, decode, 2 parked cycles
        Instr = 8'hE0; Continuar = 1'b0;
        #1;
        chk("hlt_parked", act, pk(0,0,0,0,0,2'b00,0,0,0,1,3'd5));
        Reset = 1'b0;
        #1;
        chk("hlt_reset_async", act, '0);
        @(posedge Clock);
        #1;
        chk("hlt_reset_hold", act, '0);
        MemPronto = 1'b0;
        Reset = 1'b1;
        #1;
        chk("hlt_release", act, pk(0,0,0,0,0,2'b00,1,0,0,0,3'd0));
        @(posedge Clock);
        #1;

        // ---------------- randomized instruction stream ----------------
        for (int r = 0; r < 200; r++) begin
            ins = 8'($urandom);
            if (ins[7:5] == 3'b111 && rb()) ins[4:0] = 5'd0;
            build(ins, $urandom_range(0, 3), $urandom_range(0, 3), rb(), $urandom_range(1, 4));
            run_plan($sformatf("rnd%0d_%h", r, ins), 1000, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
